// File: rtl/mandel_pixel_pool.sv
// Multi-engine Mandelbrot pixel evaluator: round-robin dispatch/collect keeps results in input order.
// Optional PIXEL_POOL_STATS_EN adds pixel_count / stall_count outputs.
module mandel_pixel_pool #(
    parameter int FRAC        = 60,
    parameter int WORD_LENGTH = 64,
    parameter int NUM_ENGINES = 4,
    parameter int ITER_W      = 10
) (
    input  logic                   sysclk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WORD_LENGTH-1:0] re_c,
    input  logic [WORD_LENGTH-1:0] im_c,
    input  logic [ITER_W-1:0]      max_iterations,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ITER_W-1:0]      depth,
    output logic [23:0]            color
`ifdef PIXEL_POOL_STATS_EN
    ,
    output logic [31:0]            pixel_count,
    output logic [31:0]            stall_count
`endif
);

    localparam int W  = WORD_LENGTH;
    localparam int PW = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
    localparam logic [PW-1:0] LAST = PW'(NUM_ENGINES - 1);
    // 4.0 at the 2*FRAC scale of a squared magnitude
    localparam logic signed [2*W:0] FOUR = (2*W+1)'(1) << (2*FRAC + 2);

    typedef enum logic [1:0] {ST_IDLE, ST_ITER, ST_DONE} eng_state_e;

    logic [PW-1:0]          dp_q, dp_d, cp_q, cp_d;
    logic [NUM_ENGINES-1:0] idle_w, done_w;
    logic [ITER_W-1:0]      dep_w [NUM_ENGINES];
    logic [23:0]            col_w [NUM_ENGINES];
    logic                   accept, collect;

    assign in_ready  = idle_w[dp_q];
    assign out_valid = done_w[cp_q];
    assign depth     = dep_w[cp_q];
    assign color     = col_w[cp_q];
    assign accept    = in_valid && in_ready;
    assign collect   = out_valid && out_ready;

    always_comb begin
        dp_d = dp_q;
        cp_d = cp_q;
        if (accept)  dp_d = (dp_q == LAST) ? '0 : dp_q + 1'b1;
        if (collect) cp_d = (cp_q == LAST) ? '0 : cp_q + 1'b1;
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            dp_q <= '0;
            cp_q <= '0;
        end else begin
            dp_q <= dp_d;
            cp_q <= cp_d;
        end
    end

    for (genvar g = 0; g < NUM_ENGINES; g++) begin : g_eng
        eng_state_e              st_q, st_d;
        logic signed [W-1:0]     zr_q, zi_q, cr_q, ci_q;
        logic [ITER_W-1:0]       n_q, max_q, dep_q;
        logic [23:0]             col_q;
        logic signed [2*W-1:0]   zr_x, zi_x, zr2, zi2, zrzi;
        logic signed [2*W:0]     mag, dif, crs;
        logic signed [W-1:0]     zr_nx, zi_nx;
        logic                    load, free, esc, hit_max;

        always_comb begin
            zr_x  = {{W{zr_q[W-1]}}, zr_q};
            zi_x  = {{W{zi_q[W-1]}}, zi_q};
            zr2   = zr_x * zr_x;
            zi2   = zi_x * zi_x;
            zrzi  = zr_x * zi_x;
            mag   = {zr2[2*W-1], zr2} + {zi2[2*W-1], zi2};
            dif   = {zr2[2*W-1], zr2} - {zi2[2*W-1], zi2};
            crs   = {zrzi, 1'b0};
            esc   = mag > FOUR;
            zr_nx = W'(dif >>> FRAC) + cr_q;
            zi_nx = W'(crs >>> FRAC) + ci_q;
        end

        assign hit_max   = (n_q == max_q);
        assign load      = accept && (dp_q == PW'(g));
        assign free      = collect && (cp_q == PW'(g));
        assign idle_w[g] = (st_q == ST_IDLE);
        assign done_w[g] = (st_q == ST_DONE);
        assign dep_w[g]  = dep_q;
        assign col_w[g]  = col_q;

        always_comb begin
            st_d = st_q;
            unique case (st_q)
                ST_IDLE: if (load) st_d = ST_ITER;
                ST_ITER: if (esc || hit_max) st_d = ST_DONE;
                ST_DONE: if (free) st_d = ST_IDLE;
                default: st_d = ST_IDLE;
            endcase
        end

        always_ff @(posedge sysclk) begin
            if (reset) st_q <= ST_IDLE;
            else       st_q <= st_d;
        end

        always_ff @(posedge sysclk) begin
            if (reset) begin
                zr_q  <= '0;
                zi_q  <= '0;
                cr_q  <= '0;
                ci_q  <= '0;
                n_q   <= '0;
                max_q <= '0;
                dep_q <= '0;
                col_q <= '0;
            end else if (load) begin
                cr_q  <= re_c;
                ci_q  <= im_c;
                max_q <= max_iterations;
                zr_q  <= '0;
                zi_q  <= '0;
                n_q   <= '0;
            end else if (st_q == ST_ITER) begin
                // escape wins over the limit test; an escape exactly at the limit is still black
                if (esc) begin
                    dep_q <= n_q;
                    col_q <= hit_max ? '0 : {n_q[7:0], n_q[5:0], 2'b00, ~n_q[7:0]};
                end else if (hit_max) begin
                    dep_q <= max_q;
                    col_q <= '0;
                end else begin
                    zr_q <= zr_nx;
                    zi_q <= zi_nx;
                    n_q  <= n_q + 1'b1;
                end
            end
        end
    end

`ifdef PIXEL_POOL_STATS_EN
    logic [31:0] pix_q, stall_q;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            pix_q   <= '0;
            stall_q <= '0;
        end else begin
            if (collect)               pix_q   <= pix_q + 1'b1;
            if (in_valid && !in_ready) stall_q <= stall_q + 1'b1;
        end
    end

    assign pixel_count = pix_q;
    assign stall_count = stall_q;
`endif

endmodule
